// File: rtl/nn_pkg.sv
// Shared types and helpers for the network memory arbiter.
// Arbiter state encoding and index width helper.
package nn_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Width of a requester index; never below one bit.
  function automatic int clog2_req(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nn_mem_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr_i.
// Purely combinational; emits one-hot grant and index.
module rr_pick
  import nn_pkg::*;
#(
  parameter  int N  = 2,
  localparam int PW = clog2_req(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  // Scan from the pointer upward with wrap-around.
  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/nn_mem_arbiter.sv
// Round-robin BRAM arbiter with optional lock and timeout.
// Read data returns one cycle after the grant, tagged.
module nn_mem_arbiter
  import nn_pkg::*;
#(
  parameter  int ADDR_LEN     = 2**16,
  parameter  int DATA_LEN     = 32,
  parameter  int NUM_REQ      = 2,
  parameter  int LOCK_TIMEOUT = 1024,
  localparam int AW           = $clog2(ADDR_LEN),
  localparam int PW           = clog2_req(NUM_REQ),
  localparam int CW           = $clog2(LOCK_TIMEOUT + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ-1:0]       req_we_i,
  input  logic [NUM_REQ-1:0]       req_lock_i,
  input  logic [NUM_REQ*AW-1:0]    req_addr_i,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  output logic [DATA_LEN-1:0]      rsp_data_o,
  output logic                     ena_o,
  output logic                     wr_ena_o,
  output logic [AW-1:0]            rd_addr_o,
  output logic [AW-1:0]            wr_addr_o,
  output logic [DATA_LEN-1:0]      wr_data_o,
  input  logic [DATA_LEN-1:0]      rd_data_i,
  output logic                     err_timeout_o
);

  arb_state_t         state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      owner;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] pend;
  logic               err;

  logic [NUM_REQ-1:0] pick_oh;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] own_oh;
  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      gidx;
  logic               xfer;
  logic               is_wr;
  logic               to_hit;

  rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req_i (req_valid_i),
    .ptr_i (ptr),
    .gnt_o (pick_oh),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Wrap-around successor of a requester index.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
    return (i == PW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Grant selection: owner only while locked, else round robin.
  always_comb begin
    own_oh        = '0;
    own_oh[owner] = 1'b1;
    gnt           = '0;
    gidx          = '0;
    if (reset_i) begin
      gnt  = '0;
      gidx = '0;
    end else if (state == ARB_LOCKED) begin
      gnt  = req_valid_i[owner] ? own_oh : '0;
      gidx = owner;
    end else begin
      gnt  = pick_any ? pick_oh : '0;
      gidx = pick_idx;
    end
  end

  assign xfer   = |gnt;
  assign is_wr  = xfer && req_we_i[gidx];
  assign to_hit = (state == ARB_LOCKED) &&
                  (cnt == CW'(LOCK_TIMEOUT - 2));

  // BRAM port muxing; idle fields are driven to zero.
  always_comb begin
    ena_o     = xfer;
    wr_ena_o  = is_wr;
    rd_addr_o = '0;
    wr_addr_o = '0;
    wr_data_o = '0;
    if (is_wr) begin
      wr_addr_o = req_addr_i[gidx*AW +: AW];
      wr_data_o = req_data_i[gidx*DATA_LEN +: DATA_LEN];
    end else if (xfer) begin
      rd_addr_o = req_addr_i[gidx*AW +: AW];
    end
  end

  assign req_ready_o   = gnt;
  assign rsp_valid_o   = reset_i ? '0 : pend;
  assign rsp_data_o    = (|rsp_valid_o) ? rd_data_i : '0;
  assign err_timeout_o = err && !reset_i;

  // Arbiter FSM, pointer, lock counter and read tag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ARB_IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
      pend  <= '0;
      err   <= 1'b0;
    end else begin
      pend <= (xfer && !is_wr) ? gnt : '0;
      unique case (state)
        ARB_IDLE: begin
          if (xfer) begin
            ptr <= nxt(gidx);
            if (req_lock_i[gidx]) begin
              state <= ARB_LOCKED;
              owner <= gidx;
              cnt   <= '0;
            end
          end
        end
        ARB_LOCKED: begin
          if (cnt != CW'(LOCK_TIMEOUT))
            cnt <= cnt + 1'b1;
          if (xfer)
            ptr <= nxt(owner);
          if (to_hit) begin
            state <= ARB_IDLE;
            ptr   <= nxt(owner);
            err   <= 1'b1;
          end else if (xfer && !req_lock_i[owner]) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_mem_arbiter.sv
// Directed bench for nn_mem_arbiter with a BRAM model.
// Table of per-cycle vectors plus a lock-timeout sequence.
module tb_nn_mem_arbiter;

  localparam int AW = 16;
  localparam int DL = 32;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] vl, we, lk;
  logic [AW-1:0] a0, a1;
  logic [DL-1:0] d0, d1;
  logic [NR-1:0] rdy, rv;
  logic [DL-1:0] rsp_d;
  logic          en, wen;
  logic [AW-1:0] ra, wa;
  logic [DL-1:0] wd;
  logic [DL-1:0] rdq;
  logic          err;

  logic [DL-1:0] mem [0:65535];

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nn_mem_arbiter #(
    .ADDR_LEN(2**16),
    .DATA_LEN(DL),
    .NUM_REQ(NR),
    .LOCK_TIMEOUT(8)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .req_valid_i  (vl),
    .req_we_i     (we),
    .req_lock_i   (lk),
    .req_addr_i   ({a1, a0}),
    .req_data_i   ({d1, d0}),
    .req_ready_o  (rdy),
    .rsp_valid_o  (rv),
    .rsp_data_o   (rsp_d),
    .ena_o        (en),
    .wr_ena_o     (wen),
    .rd_addr_o    (ra),
    .wr_addr_o    (wa),
    .wr_data_o    (wd),
    .rd_data_i    (rdq),
    .err_timeout_o(err)
  );

  always @(posedge clk) begin
    if (en && wen) mem[wa] <= wd;
    else if (en) rdq <= mem[ra];
  end

  typedef struct {
    logic          r;
    logic [1:0]    vl, we, lk;
    logic [15:0]   a0, a1;
    logic [31:0]   d0, d1;
    logic [1:0]    rdy, rv;
    logic [31:0]   rd;
    logic          en, wen;
    logic [15:0]   ra, wa;
    logic [31:0]   wd;
    logic          err;
  } vec_t;

  vec_t tv[$];

  function automatic void add(
    input logic r, input logic [1:0] v, w, l,
    input logic [15:0] x0, x1, input logic [31:0] y0, y1,
    input logic [1:0] ery, erv, input logic [31:0] erd,
    input logic een, ewe, input logic [15:0] era, ewa,
    input logic [31:0] ewd, input logic eer);
    vec_t t;
    t.r = r; t.vl = v; t.we = w; t.lk = l;
    t.a0 = x0; t.a1 = x1; t.d0 = y0; t.d1 = y1;
    t.rdy = ery; t.rv = erv; t.rd = erd;
    t.en = een; t.wen = ewe; t.ra = era; t.wa = ewa;
    t.wd = ewd; t.err = eer;
    tv.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    rst = 0; vl = 0; we = 0; lk = 0;
    a0 = 0; a1 = 0; d0 = 0; d1 = 0;
  endtask

  logic [102:0] act_v, exp_v;
  int n;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = {16'hA5A5, 16'(i)};
    mem[2] = 32'h3F80_0000;
    rdq = 0;
    idle_in();
    rst = 1;

    add(1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0);
    add(0,1,0,0, 16'h2,0,0,0, 1,0,0, 1,0,16'h2,0,0,0);
    add(0,0,0,0, 0,0,0,0, 0,1,32'h3F800000, 0,0,0,0,0,0);
    add(1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0);
    add(0,3,0,0, 16'h10,16'h20,0,0, 1,0,0, 1,0,16'h10,0,0,0);
    add(0,3,0,0, 16'h11,16'h21,0,0, 2,1,32'hA5A50010, 1,0,16'h21,0,0,0);
    add(0,3,0,0, 16'h12,16'h22,0,0, 1,2,32'hA5A50021, 1,0,16'h12,0,0,0);
    add(0,3,0,0, 16'h13,16'h23,0,0, 2,1,32'hA5A50012, 1,0,16'h23,0,0,0);
    add(0,3,0,0, 16'h14,16'h24,0,0, 1,2,32'hA5A50023, 1,0,16'h14,0,0,0);
    add(0,3,0,0, 16'h15,16'h25,0,0, 2,1,32'hA5A50014, 1,0,16'h25,0,0,0);
    add(0,1,0,0, 16'h30,0,0,0, 1,2,32'hA5A50025, 1,0,16'h30,0,0,0);
    add(0,3,2,2, 16'h40,16'h64,0,32'h12345678,
        2,1,32'hA5A50030, 1,1,0,16'h64,32'h12345678,0);
    add(0,3,0,2, 16'h40,16'h64,0,0, 2,0,0, 1,0,16'h64,0,0,0);
    add(0,3,0,2, 16'h40,16'h65,0,0, 2,2,32'h12345678, 1,0,16'h65,0,0,0);
    add(0,3,0,0, 16'h40,16'h66,0,0, 2,2,32'hA5A50065, 1,0,16'h66,0,0,0);
    add(0,3,0,0, 16'h40,16'h66,0,0, 1,2,32'hA5A50066, 1,0,16'h40,0,0,0);
    add(0,0,0,0, 0,0,0,0, 0,1,32'hA5A50040, 0,0,0,0,0,0);
    add(0,2,2,0, 0,16'hFF,0,32'hDEADBEEF,
        2,0,0, 1,1,0,16'hFF,32'hDEADBEEF,0);
    add(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0);
    add(0,1,0,1, 16'h7,0,0,0, 1,0,0, 1,0,16'h7,0,0,0);
    add(0,2,0,0, 0,16'h8,0,0, 0,1,32'hA5A50007, 0,0,0,0,0,0);
    for (int i = 0; i < 6; i++)
      add(0,2,0,0, 0,16'h8,0,0, 0,0,0, 0,0,0,0,0,0);
    add(0,2,0,0, 0,16'h8,0,0, 2,0,0, 1,0,16'h8,0,0,1);
    add(0,0,0,0, 0,0,0,0, 0,2,32'hA5A50008, 0,0,0,0,0,1);
    add(0,1,0,0, 16'h5,0,0,0, 1,0,0, 1,0,16'h5,0,0,1);
    add(1,1,0,0, 16'h5,0,0,0, 0,0,0, 0,0,0,0,0,0);
    add(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0);
    add(0,3,0,0, 16'h1,16'h2,0,0, 1,0,0, 1,0,16'h1,0,0,0);
    add(0,0,0,0, 0,0,0,0, 0,1,32'hA5A50001, 0,0,0,0,0,0);

    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst = tv[i].r; vl = tv[i].vl; we = tv[i].we; lk = tv[i].lk;
      a0 = tv[i].a0; a1 = tv[i].a1; d0 = tv[i].d0; d1 = tv[i].d1;
      #1;
      act_v = {rdy, rv, rsp_d, en, wen, ra, wa, wd, err};
      exp_v = {tv[i].rdy, tv[i].rv, tv[i].rd, tv[i].en,
               tv[i].wen, tv[i].ra, tv[i].wa, tv[i].wd,
               tv[i].err};
      chk($sformatf("vec%0d", i), 128'(act_v), 128'(exp_v));
    end

    @(negedge clk);
    idle_in();
    vl = 2'b11; lk = 2'b10; a0 = 16'h70; a1 = 16'h71;
    #1;
    chk("lock_grant", 128'(rdy), 128'(2'b10));
    n = 1;
    while (n <= 20) begin
      @(negedge clk);
      #1;
      if (rdy[0]) break;
      chk($sformatf("held_%0d", n), 128'(rdy), 128'(2'b10));
      n++;
    end
    chk("release_cycle", 128'(n), 128'(8));
    chk("err_sticky", 128'(err), 128'(1));

    @(negedge clk);
    idle_in();
    #1;
    chk("idle_quiet", 128'({en, rdy}), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_mem_arbiter.md
Name: nn_mem_arbiter

Overview:
Shares the single-write/dual-read network BRAM between NUM_REQ requesters, such as the inference sequencer, the weight loader and the host readback path. It uses round-robin arbitration with one transfer per cycle and an optional lock for multi-cycle sequences. Only BRAM read port 1 is used; read data returns one cycle after the transfer, tagged to its requester. The block sits between the requesters and the BRAM instance.

Parameters:
ADDR_LEN, 2**16, BRAM depth in words; AW = $clog2(ADDR_LEN)
DATA_LEN, 32, word width
NUM_REQ, 2, number of requesters (2..8)
LOCK_TIMEOUT, 1024, maximum cycles a lock may be held before forced release

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_we_i  in  NUM_REQ  1 = write, 0 = read
req_lock_i  in  NUM_REQ  keep grant after this transfer
req_addr_i  in  NUM_REQ*AW  packed addresses, requester i at [i*AW +: AW]
req_data_i  in  NUM_REQ*DATA_LEN  packed write data
req_ready_o  out  NUM_REQ  one-hot grant; transfer = valid & ready
rsp_valid_o  out  NUM_REQ  one-hot read-data valid
rsp_data_o  out  DATA_LEN  read data, shared by all requesters
ena_o  out  1  BRAM enable
wr_ena_o  out  1  BRAM write enable
rd_addr_o  out  AW  BRAM read address 1
wr_addr_o  out  AW  BRAM write address
wr_data_o  out  DATA_LEN  BRAM write data
rd_data_i  in  DATA_LEN  BRAM data_1 output (1-cycle latency)
err_timeout_o  out  1  sticky; set on forced lock release

Behaviour:
- Reset: state ARB_IDLE, rr pointer 0, lock counter 0, pending read cleared. All outputs 0, including err_timeout_o.
- req_ready_o is combinational from the registered state and the current req_valid_i. At most one bit is set, and never for a requester whose valid is low.
- ARB_IDLE: grant the first valid requester scanning from ptr upward, with wrap-around. If none is valid, no grant.
- Pointer update: on a transfer by requester g, ptr <= (g+1) mod NUM_REQ. The pointer is unchanged when there is no transfer.
- On a transfer with req_lock_i[g]=1: move to ARB_LOCKED, owner <= g, lock counter <= 0.
- ARB_LOCKED:
  - Only the owner can be granted. ready = valid[owner].
  - The counter increments every cycle and saturates at LOCK_TIMEOUT.
  - A transfer with lock=0 returns the block to ARB_IDLE; ptr advances past the owner.
  - When the counter reaches LOCK_TIMEOUT-1 without release: return to ARB_IDLE, ptr <= owner+1, set err_timeout_o. A transfer in that same cycle still completes.
- Write transfer: in the same cycle, ena_o=1, wr_ena_o=1, wr_addr_o=addr, wr_data_o=data. No response is generated.
- Read transfer: in the same cycle, ena_o=1, rd_addr_o=addr. In the next cycle, rsp_valid_o[g]=1 and rsp_data_o=rd_data_i.
- rsp_data_o is 0 when no response is valid.
- Back-to-back reads give one response per cycle, in grant order.
- Outputs with no transfer: ena_o=0, wr_ena_o=0, addresses and data 0.
- Read and write to the same address on consecutive cycles: the BRAM's behaviour applies. The arbiter performs no forwarding.
- Reset asserted mid-operation:
  - Any pending response is dropped; rsp_valid_o=0 in the cycle after reset.
  - Any lock is released.
  - err_timeout_o clears. Reset is the only way to clear it.
- Owner in ARB_LOCKED drops valid: no grant that cycle, and the lock is held; the timeout still runs.
- All widths are unsigned. Address slicing uses fixed AW-wide fields.

Decomposition:
- nn_pkg: arb_state_t enum {ARB_IDLE, ARB_LOCKED} and function clog2_req() for the owner and pointer width.
- Sub-module rr_pick: purely combinational. Inputs are a NUM_REQ request vector and the pointer; output is a one-hot grant plus the encoded index.
- nn_mem_arbiter holds the FSM, pointer, lock counter, pending-read tag and BRAM muxing.

Test Plan:
- Reads only: requester 0 reads addr 0x0002 while requester 1 is idle, with BRAM[2]=0x3F800000. Required: ready_o=01; next cycle rsp_valid_o=01 and rsp_data_o=0x3F800000.
- Fairness: both requesters issue reads every cycle for 6 cycles from reset. Required grants 0,1,0,1,0,1 and responses tagged the same, each one cycle later.
- Lock: requester 1 writes addr 0x0064 with lock=1, then holds valid on 3 reads with lock=1,1,0 while requester 0 is valid throughout. Required: requester 0 gets no grant until the cycle after the lock=0 transfer, then is granted.
- Timeout: with LOCK_TIMEOUT=8, requester 0 transfers with lock=1, then drops valid while requester 1 is valid. Required: requester 1 is granted 8 cycles after the lock transfer and err_timeout_o=1 sticky.
- Mid-read reset: requester 0 reads addr 5, and reset_i is asserted the next cycle. Required: rsp_valid_o=0, all outputs 0, ptr=0, err_timeout_o=0.
- Write path: requester 1 writes 0xDEADBEEF to 0x00FF. Required in the same cycle: wr_ena_o=1, wr_addr_o=0x00FF, wr_data_o=0xDEADBEEF, and no rsp_valid_o afterwards.
